// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the in-order 5-stage pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle EX freeze and saturating perf counters.
module hazard_ctrl_unit #(
    parameter int REG_AW         = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int BR_RESOLVE_MEM = 0,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_we,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_we,
    input  logic              exmem_mem_read,
    input  logic              branch_taken,
    input  logic              mc_busy,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } state_t;

    localparam logic [1:0]       CNT_INIT = 2'(LOAD_USE_STALL - 1);
    localparam bit               MULTI_BUBBLE = (LOAD_USE_STALL > 1);
    localparam bit               MEM_CHECK = (LOAD_USE_STALL >= 2);
    localparam bit               BR_MEM = (BR_RESOLVE_MEM != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       hz_ex, hz_mem, hz;
    logic       stall_ev, flush_ev;

    // Load-use match against the load in EX, and against the load in MEM
    // when there is no MEM->EX load forwarding.
    always_comb begin
        hz_ex  = idex_we & idex_mem_read & (idex_rd != '0) &
                 ((id_rs1_used & (id_rs1 == idex_rd)) |
                  (id_rs2_used & (id_rs2 == idex_rd)));
        hz_mem = exmem_we & exmem_mem_read & (exmem_rd != '0) &
                 ((id_rs1_used & (id_rs1 == exmem_rd)) |
                  (id_rs2_used & (id_rs2 == exmem_rd)));
        hz     = hz_ex | (MEM_CHECK & hz_mem);
    end

    // Prioritised control outputs and next-state; reset forces the
    // flush-everything pattern combinationally.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;

        if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = BR_MEM;
            state_nxt   = RUN;
            cnt_nxt     = '0;
            flush_ev    = 1'b1;
        end else if (mc_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            stall_ev    = 1'b1;
        end else if (state == LSTALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            cnt_nxt    = cnt - 2'd1;
            if (cnt == 2'd1) begin
                state_nxt = RUN;
            end
            stall_ev   = 1'b1;
        end else if (hz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (MULTI_BUBBLE) begin
                state_nxt = LSTALL;
                cnt_nxt   = CNT_INIT;
            end
            stall_ev   = 1'b1;
        end

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end
    end

    // FSM state and bubble down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_ev && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three configurations driven in parallel,
// directed scenarios plus randomized traffic against a bubble-count model.
module tb_hazard_ctrl_unit;

    localparam logic [5:0] V_IDLE   = 6'b111000;
    localparam logic [5:0] V_STALL  = 6'b001010;
    localparam logic [5:0] V_FREEZE = 6'b000001;
    localparam logic [5:0] V_RST    = 6'b000111;

    // Per-instance configuration: LOAD_USE_STALL, BR_RESOLVE_MEM, counter max.
    int lus  [3] = '{1, 2, 3};
    int brm  [3] = '{0, 1, 0};
    int cmax [3] = '{65535, 3, 65535};

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, idex_rd, exmem_rd;
    logic       id_rs1_used, id_rs2_used, idex_we, idex_mem_read;
    logic       exmem_we, exmem_mem_read, branch_taken, mc_busy, perf_clr;

    logic [2:0]  pw, iw, xw, ifl, idf, exf;
    logic [15:0] sc0, fc0, sc2, fc2;
    logic [1:0]  sc1, fc1;

    int checks = 0;
    int errors = 0;

    // Model state: remaining forced bubbles and counter values per instance.
    int m_rem [3];
    int m_sc  [3];
    int m_fc  [3];
    int n_rem [3];
    int n_sc  [3];
    int n_fc  [3];
    logic [5:0] exp_ctl [3];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_STALL(1), .BR_RESOLVE_MEM(0), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .idex_rd(idex_rd), .idex_we(idex_we), .idex_mem_read(idex_mem_read),
        .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_mem_read(exmem_mem_read),
        .branch_taken(branch_taken), .mc_busy(mc_busy), .perf_clr(perf_clr),
        .pc_write(pw[0]), .ifid_write(iw[0]), .idex_write(xw[0]),
        .ifid_flush(ifl[0]), .idex_flush(idf[0]), .exmem_flush(exf[0]),
        .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_STALL(2), .BR_RESOLVE_MEM(1), .CNT_W(2)) d2 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .idex_rd(idex_rd), .idex_we(idex_we), .idex_mem_read(idex_mem_read),
        .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_mem_read(exmem_mem_read),
        .branch_taken(branch_taken), .mc_busy(mc_busy), .perf_clr(perf_clr),
        .pc_write(pw[1]), .ifid_write(iw[1]), .idex_write(xw[1]),
        .ifid_flush(ifl[1]), .idex_flush(idf[1]), .exmem_flush(exf[1]),
        .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_STALL(3), .BR_RESOLVE_MEM(0), .CNT_W(16)) d3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .idex_rd(idex_rd), .idex_we(idex_we), .idex_mem_read(idex_mem_read),
        .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_mem_read(exmem_mem_read),
        .branch_taken(branch_taken), .mc_busy(mc_busy), .perf_clr(perf_clr),
        .pc_write(pw[2]), .ifid_write(iw[2]), .idex_write(xw[2]),
        .ifid_flush(ifl[2]), .idex_flush(idf[2]), .exmem_flush(exf[2]),
        .stall_cnt(sc2), .flush_cnt(fc2));

    function automatic logic [5:0] ctl_of(int i);
        return {pw[i], iw[i], xw[i], ifl[i], idf[i], exf[i]};
    endfunction

    function automatic int sc_of(int i);
        if (i == 0) return int'(sc0);
        if (i == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    function automatic int fc_of(int i);
        if (i == 0) return int'(fc0);
        if (i == 1) return int'(fc1);
        return int'(fc2);
    endfunction

    function automatic logic [5:0] v_branch(int i);
        return {5'b11111, brm[i] != 0};
    endfunction

    function automatic int sat_inc(int v, int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // A consumer in ID waits on a load whose result is not yet forwardable.
    function automatic bit uses_load(int lus_i);
        bit ex_hit, mem_hit;
        ex_hit  = idex_we && idex_mem_read && idex_rd != 0 &&
                  ((id_rs1_used && id_rs1 == idex_rd) || (id_rs2_used && id_rs2 == idex_rd));
        mem_hit = exmem_we && exmem_mem_read && exmem_rd != 0 &&
                  ((id_rs1_used && id_rs1 == exmem_rd) || (id_rs2_used && id_rs2 == exmem_rd));
        return ex_hit || (lus_i >= 2 && mem_hit);
    endfunction

    task automatic model_eval();
        for (int i = 0; i < 3; i++) begin
            n_rem[i] = m_rem[i];
            n_sc[i]  = m_sc[i];
            n_fc[i]  = m_fc[i];
            if (branch_taken) begin
                exp_ctl[i] = v_branch(i);
                n_rem[i]   = 0;
                n_fc[i]    = sat_inc(m_fc[i], cmax[i]);
            end else if (mc_busy) begin
                exp_ctl[i] = V_FREEZE;
                n_sc[i]    = sat_inc(m_sc[i], cmax[i]);
            end else if (m_rem[i] > 0 || uses_load(lus[i])) begin
                exp_ctl[i] = V_STALL;
                n_rem[i]   = (m_rem[i] > 0) ? m_rem[i] - 1 : lus[i] - 1;
                n_sc[i]    = sat_inc(m_sc[i], cmax[i]);
            end else begin
                exp_ctl[i] = V_IDLE;
            end
            if (perf_clr) begin
                n_sc[i] = 0;
                n_fc[i] = 0;
            end
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < 3; i++) begin
            m_rem[i] = n_rem[i];
            m_sc[i]  = n_sc[i];
            m_fc[i]  = n_fc[i];
        end
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        idex_rd = 5'd0; idex_we = 1'b0; idex_mem_read = 1'b0;
        exmem_rd = 5'd0; exmem_we = 1'b0; exmem_mem_read = 1'b0;
        branch_taken = 1'b0; mc_busy = 1'b0; perf_clr = 1'b0;
    endtask

    // lw x5 in EX, add reading x5 as rs1 in ID.
    task automatic set_hazard();
        set_idle();
        idex_rd = 5'd5; idex_we = 1'b1; idex_mem_read = 1'b1;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
    endtask

    task automatic clear_perf();
        set_idle();
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        branch_taken = 1'b1;
        mc_busy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_of(i) !== V_RST) begin
                errors++;
                $display("FAIL reset_ctl inst%0d got=%b exp=%b", i, ctl_of(i), V_RST);
            end
            checks++;
            if (sc_of(i) != 0 || fc_of(i) != 0) begin
                errors++;
                $display("FAIL reset_cnt inst%0d got stall=%0d flush=%0d exp 0/0", i, sc_of(i), fc_of(i));
            end
        end
        @(posedge clk); #1;
        set_idle();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_of(i) !== V_IDLE) begin
                errors++;
                $display("FAIL reset_release inst%0d got=%b exp=%b", i, ctl_of(i), V_IDLE);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        logic [5:0] e;
        clear_perf();
        set_hazard();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = (k < lus[i]) ? V_STALL : V_IDLE;
                checks++;
                if (ctl_of(i) !== e) begin
                    errors++;
                    $display("FAIL load_use cyc%0d inst%0d got=%b exp=%b", k, i, ctl_of(i), e);
                end
            end
            @(posedge clk); #1;
            set_idle();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sc_of(i) != lus[i] || fc_of(i) != 0) begin
                errors++;
                $display("FAIL load_use_cnt inst%0d got stall=%0d flush=%0d exp %0d/0",
                         i, sc_of(i), fc_of(i), lus[i]);
            end
        end
    endtask

    task automatic test_no_hazard();
        clear_perf();
        for (int k = 0; k < 2; k++) begin
            set_hazard();
            if (k == 0) begin
                idex_rd = 5'd0; id_rs1 = 5'd0;
            end else begin
                id_rs1_used = 1'b0; id_rs2 = 5'd5; id_rs2_used = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ctl_of(i) !== V_IDLE) begin
                    errors++;
                    $display("FAIL no_hazard case%0d inst%0d got=%b exp=%b", k, i, ctl_of(i), V_IDLE);
                end
            end
            @(posedge clk); #1;
        end
        set_idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sc_of(i) != 0) begin
                errors++;
                $display("FAIL no_hazard_cnt inst%0d got=%0d exp=0", i, sc_of(i));
            end
        end
    endtask

    task automatic test_branch_in_stall();
        logic [5:0] e;
        clear_perf();
        set_hazard();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = (k == 0) ? V_STALL : (k == 1) ? v_branch(i) : V_IDLE;
                checks++;
                if (ctl_of(i) !== e) begin
                    errors++;
                    $display("FAIL branch_in_stall cyc%0d inst%0d got=%b exp=%b", k, i, ctl_of(i), e);
                end
            end
            @(posedge clk); #1;
            set_idle();
            branch_taken = (k == 0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sc_of(i) != 1 || fc_of(i) != 1) begin
                errors++;
                $display("FAIL branch_in_stall_cnt inst%0d got stall=%0d flush=%0d exp 1/1",
                         i, sc_of(i), fc_of(i));
            end
        end
    endtask

    task automatic test_mc_busy();
        clear_perf();
        mc_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ctl_of(i) !== V_FREEZE) begin
                    errors++;
                    $display("FAIL mc_busy cyc%0d inst%0d got=%b exp=%b", k, i, ctl_of(i), V_FREEZE);
                end
            end
            @(posedge clk); #1;
        end
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sc_of(i) != ((cmax[i] < 4) ? cmax[i] : 4)) begin
                errors++;
                $display("FAIL mc_busy_cnt inst%0d got=%0d exp=%0d", i, sc_of(i), (cmax[i] < 4) ? cmax[i] : 4);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_of(i) !== v_branch(i)) begin
                errors++;
                $display("FAIL mc_busy_branch inst%0d got=%b exp=%b", i, ctl_of(i), v_branch(i));
            end
        end
        @(posedge clk); #1;
        set_idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fc_of(i) != 1) begin
                errors++;
                $display("FAIL mc_busy_branch_cnt inst%0d got=%0d exp=1", i, fc_of(i));
            end
        end
    endtask

    task automatic test_saturate_clear();
        clear_perf();
        mc_busy = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sc_of(i) != ((cmax[i] < 5) ? cmax[i] : 5)) begin
                errors++;
                $display("FAIL saturate inst%0d got=%0d exp=%0d", i, sc_of(i), (cmax[i] < 5) ? cmax[i] : 5);
            end
        end
        perf_clr = 1'b1;
        @(posedge clk); #1;
        set_idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sc_of(i) != 0) begin
                errors++;
                $display("FAIL clear_with_stall inst%0d got=%0d exp=0", i, sc_of(i));
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        set_hazard();
        @(posedge clk); #1;
        set_idle();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_of(i) !== V_RST || sc_of(i) != 0) begin
                errors++;
                $display("FAIL reset_mid_stall inst%0d got ctl=%b stall=%0d exp ctl=%b stall=0",
                         i, ctl_of(i), sc_of(i), V_RST);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_of(i) !== V_IDLE) begin
                errors++;
                $display("FAIL reset_mid_stall_run inst%0d got=%b exp=%b", i, ctl_of(i), V_IDLE);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        rst = 1'b1;
        set_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        for (int k = 0; k < 600; k++) begin
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            id_rs1_used    = 1'($urandom);
            id_rs2_used    = 1'($urandom);
            idex_rd        = 5'($urandom_range(0, 3));
            idex_we        = ($urandom_range(0, 3) != 0);
            idex_mem_read  = 1'($urandom);
            exmem_rd       = 5'($urandom_range(0, 3));
            exmem_we       = ($urandom_range(0, 3) != 0);
            exmem_mem_read = 1'($urandom);
            branch_taken   = ($urandom_range(0, 11) == 0);
            mc_busy        = ($urandom_range(0, 7) == 0);
            perf_clr       = ($urandom_range(0, 39) == 0);
            model_eval();
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ctl_of(i) !== exp_ctl[i]) begin
                    errors++;
                    $display("FAIL random_ctl cyc%0d inst%0d got=%b exp=%b", k, i, ctl_of(i), exp_ctl[i]);
                end
                checks++;
                if (sc_of(i) != m_sc[i] || fc_of(i) != m_fc[i]) begin
                    errors++;
                    $display("FAIL random_cnt cyc%0d inst%0d got stall=%0d flush=%0d exp %0d/%0d",
                             k, i, sc_of(i), fc_of(i), m_sc[i], m_fc[i]);
                end
            end
            @(posedge clk); #1;
            model_commit();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_in_stall();
        test_mc_busy();
        test_saturate_clear();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard controller for the in-order 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Detects load-use data hazards over a configurable bubble depth, applies taken-branch flushes for a configurable resolve stage, and freezes the front end while a multi-cycle EX unit is busy.
- Adds saturating performance counters for stall cycles and flush events.
- Sits beside the ID stage and drives the PC and pipeline-register write/flush controls.

Parameters:
- REG_AW, 5, register address width; address 0 never hazards.
- LOAD_USE_STALL, 1, bubble cycles per load-use hazard (1 = MEM->EX forwarding, 2 = no load forwarding); legal 1..3.
- BR_RESOLVE_MEM, 0, 0 = branch resolved in EX, 1 = resolved in MEM (also flushes EX/MEM).
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_rs1  in  REG_AW  ID-stage source 1
- id_rs2  in  REG_AW  ID-stage source 2
- id_rs1_used  in  1  instruction in ID reads rs1
- id_rs2_used  in  1  instruction in ID reads rs2
- idex_rd  in  REG_AW  ID/EX destination
- idex_we  in  1  ID/EX writes register file
- idex_mem_read  in  1  ID/EX is a load
- exmem_rd  in  REG_AW  EX/MEM destination
- exmem_we  in  1  EX/MEM writes register file
- exmem_mem_read  in  1  EX/MEM is a load
- branch_taken  in  1  taken branch/jump resolved this cycle
- mc_busy  in  1  multi-cycle EX unit (mul/div) busy
- perf_clr  in  1  synchronous clear of performance counters
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID write enable
- idex_write  out  1  ID/EX write enable
- ifid_flush  out  1  IF/ID bubble insert
- idex_flush  out  1  ID/EX bubble insert
- exmem_flush  out  1  EX/MEM bubble insert
- stall_cnt  out  CNT_W  stall cycles counted
- flush_cnt  out  CNT_W  taken-branch flush events counted

Behaviour:
- FSM states: RUN, LSTALL. A 2-bit down-counter `cnt` is used in LSTALL.
- Reset (async, while rst=1):
  - State RUN, cnt=0, stall_cnt=0, flush_cnt=0.
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1.
- Hazard match `hz` is true when any of the following hold:
  - idex_we & idex_mem_read & idex_rd!=0 & ((id_rs1_used & id_rs1==idex_rd) | (id_rs2_used & id_rs2==idex_rd)).
  - LOAD_USE_STALL>=2 only: the same test applied to exmem_rd / exmem_we / exmem_mem_read.
- Default outputs (no event): write enables = 1, all flushes = 0.
- Event priority, highest first: branch_taken > mc_busy > load-use stall.
- branch_taken (any state), same cycle:
  - pc_write=1, ifid_write=1, idex_write=1, ifid_flush=1, idex_flush=1, exmem_flush=BR_RESOLVE_MEM.
  - Next state RUN and cnt=0; any pending load-use stall is cancelled because the dependent instruction is squashed.
  - flush_cnt += 1.
- mc_busy (no branch_taken):
  - pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1, other flushes 0.
  - State and cnt hold; a pending LSTALL does not decrement.
  - stall_cnt += 1.
- RUN with hz (no branch, no mc_busy):
  - pc_write=0, ifid_write=0, idex_flush=1.
  - If LOAD_USE_STALL>1: go to LSTALL with cnt=LOAD_USE_STALL-1; otherwise stay in RUN.
  - stall_cnt += 1.
- LSTALL (no branch, no mc_busy):
  - Same stall outputs as RUN-with-hz, applied regardless of the current hz value.
  - cnt decrements each cycle; go to RUN when cnt==1 at the clock edge.
  - stall_cnt += 1.
- Total bubble length per isolated load-use hazard is exactly LOAD_USE_STALL cycles.
- Control outputs are combinational from state and inputs; zero-cycle latency.
- Performance counters:
  - Saturate at all-ones and never wrap.
  - perf_clr zeroes both counters at the clock edge and takes priority over any increment in that cycle.

Test Plan:
- LOAD_USE_STALL=1: lw x5 in ID/EX (idex_rd=5, mem_read=1, we=1) with ID add rs1=5, rs1_used=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1.
- Same hazard with idex_rd=0, or with rs2=5 and id_rs2_used=0 -> no stall; all enables 1, all flushes 0.
- LOAD_USE_STALL=2: load-use hazard -> stall outputs for exactly 2 cycles, then RUN; stall_cnt=2.
- LOAD_USE_STALL=3, branch_taken in the 2nd stall cycle -> in that cycle ifid_flush=1, idex_flush=1, pc_write=1; state RUN next cycle; flush_cnt=1, stall_cnt=1.
- mc_busy held 4 cycles during RUN -> pc_write=0, idex_write=0, exmem_flush=1 for 4 cycles; stall_cnt=4. With BR_RESOLVE_MEM=1, branch_taken -> exmem_flush=1.
- CNT_W=2, 5 stall cycles -> stall_cnt saturates at 3. perf_clr asserted together with a stall -> counter reads 0. rst pulsed mid-LSTALL -> outputs take reset values immediately; RUN after release.
